// File: rtl/bram_arb_pkg.sv
// Shared definitions for the dual-port BRAM arbiter: read latency and the
// per-port pipeline entry that tracks which requester a read belongs to.
package bram_arb_pkg;

    localparam int RD_LAT = 2;
    // Wide enough for the largest supported requester count (8).
    localparam int ID_W   = 3;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } pipe_entry_t;

endpackage

// File: rtl/bram_arb_rr_pick.sv
// Round-robin search: first set bit of mask, scanning upward from start
// and wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] first,
    output logic          found
);

    int j;

    // Scan from the far end so the candidate closest to start wins last.
    always_comb begin
        first = '0;
        found = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (mask[j]) begin
                first = j[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_arb.sv
// Two-grant round-robin arbiter in front of a dual-port BRAM with a 2-cycle
// read; returns read data to the originating requester.
module bram_arb
    import bram_arb_pkg::*;
#(
    parameter int ADDR_ = 8,
    parameter int DATA_ = 8,
    parameter int N_    = 4
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic [N_-1:0]             req,
    input  logic [N_-1:0]             we,
    input  logic [N_-1:0][ADDR_-1:0]  addr,
    input  logic [N_-1:0][DATA_-1:0]  wdata,
    output logic [N_-1:0]             gnt,
    output logic [N_-1:0]             rvalid,
    output logic [N_-1:0][DATA_-1:0]  rdata,
    output logic                      wea,
    output logic                      web,
    output logic [ADDR_-1:0]          addra,
    output logic [ADDR_-1:0]          addrb,
    output logic [DATA_-1:0]          dina,
    output logic [DATA_-1:0]          dinb,
    input  logic [DATA_-1:0]          douta,
    input  logic [DATA_-1:0]          doutb
);

    localparam int IW = $clog2(N_);

    logic [IW-1:0]  ptr_reg;
    logic [IW-1:0]  ptr_next;
    logic [IW-1:0]  last_idx;
    logic [IW-1:0]  idx_a;
    logic [IW-1:0]  idx_b;
    logic           found_a;
    logic           found_b;
    logic [N_-1:0]  mask_b;
    pipe_entry_t    entry_a;
    pipe_entry_t    entry_b;
    pipe_entry_t [RD_LAT-1:0] pipe_a_reg;
    pipe_entry_t [RD_LAT-1:0] pipe_b_reg;

    rr_pick #(.N(N_), .IW(IW)) u_pick_a (
        .mask  (req),
        .start (ptr_reg),
        .first (idx_a),
        .found (found_a)
    );

    // Port B may not touch port A's address when either side writes.
    generate
        for (genvar gi = 0; gi < N_; gi++) begin : g_mask
            assign mask_b[gi] = req[gi] && (IW'(gi) != idx_a) &&
                                !((addr[gi] == addr[idx_a]) && (we[gi] || we[idx_a]));
        end
    endgenerate

    rr_pick #(.N(N_), .IW(IW)) u_pick_b (
        .mask  (mask_b),
        .start (ptr_reg),
        .first (idx_b),
        .found (found_b)
    );

    always_comb begin
        gnt   = '0;
        wea   = 1'b0;
        web   = 1'b0;
        addra = '0;
        addrb = '0;
        dina  = '0;
        dinb  = '0;
        if (!aclr) begin
            if (found_a) begin
                gnt[idx_a] = 1'b1;
                wea        = we[idx_a];
                addra      = addr[idx_a];
                dina       = wdata[idx_a];
            end
            if (found_b) begin
                gnt[idx_b] = 1'b1;
                web        = we[idx_b];
                addrb      = addr[idx_b];
                dinb       = wdata[idx_b];
            end
        end
    end

    always_comb begin
        last_idx = found_b ? idx_b : idx_a;
        ptr_next = (last_idx == IW'(N_ - 1)) ? '0 : last_idx + IW'(1);
    end

    assign entry_a = '{valid: found_a && !we[idx_a], id: ID_W'(idx_a)};
    assign entry_b = '{valid: found_b && !we[idx_b], id: ID_W'(idx_b)};

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            ptr_reg    <= '0;
            pipe_a_reg <= '0;
            pipe_b_reg <= '0;
        end else begin
            if (found_a) begin
                ptr_reg <= ptr_next;
            end
            pipe_a_reg[0] <= entry_a;
            pipe_b_reg[0] <= entry_b;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_a_reg[s] <= pipe_a_reg[s-1];
                pipe_b_reg[s] <= pipe_b_reg[s-1];
            end
        end
    end

    // A and B never carry the same requester, so at most one hit per id.
    generate
        for (genvar gi = 0; gi < N_; gi++) begin : g_ret
            logic hit_a;
            logic hit_b;
            assign hit_a = pipe_a_reg[RD_LAT-1].valid && (pipe_a_reg[RD_LAT-1].id == ID_W'(gi));
            assign hit_b = pipe_b_reg[RD_LAT-1].valid && (pipe_b_reg[RD_LAT-1].id == ID_W'(gi));
            assign rvalid[gi] = hit_a || hit_b;
            assign rdata[gi]  = hit_a ? douta : (hit_b ? doutb : '0);
        end
    endgenerate

endmodule

// File: tb/tb_bram_arb.sv
// Randomized and directed bench for bram_arb against a behavioural model of
// the arbitration rules, a reference memory and a 2-cycle BRAM.
module tb_bram_arb;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic                   clk = 1'b0;
    logic                   aclr;
    logic [N-1:0]           req, we, gnt, rvalid;
    logic [N-1:0][AW-1:0]   addr;
    logic [N-1:0][DW-1:0]   wdata, rdata;
    logic                   wea, web;
    logic [AW-1:0]          addra, addrb;
    logic [DW-1:0]          dina, dinb, douta, doutb;

    always #5 clk = ~clk;

    bram_arb #(.ADDR_(AW), .DATA_(DW), .N_(N)) dut (
        .clk    (clk),
        .aclr   (aclr),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .wea    (wea),
        .web    (web),
        .addra  (addra),
        .addrb  (addrb),
        .dina   (dina),
        .dinb   (dinb),
        .douta  (douta),
        .doutb  (doutb)
    );

    // Dual-port BRAM, write-first, two registered read stages.
    logic [DW-1:0] bram [256];
    logic [DW-1:0] refmem [256];
    logic [DW-1:0] ra1, ra2, rb1, rb2;
    logic          load;

    always @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < 256; j++) bram[j] <= refmem[j];
        end else begin
            if (wea) bram[addra] <= dina;
            if (web) bram[addrb] <= dinb;
        end
        ra1 <= wea ? dina : bram[addra];
        rb1 <= web ? dinb : bram[addrb];
        ra2 <= ra1;
        rb2 <= rb1;
    end
    assign douta = ra2;
    assign doutb = rb2;

    // Requester state and reference model.
    logic [N-1:0]         r_req, r_we;
    logic [AW-1:0]        r_addr [N];
    logic [DW-1:0]        r_wdata [N];
    int                   m_ptr;
    logic [N-1:0]         p1_v, p2_v;
    logic [DW-1:0]        p1_d [N];
    logic [DW-1:0]        p2_d [N];
    int                   wait_cnt [N];
    int                   mode;
    bit                   verbose;
    int                   cyc;
    int                   n_vec = 0;
    int                   n_err = 0;

    logic [N-1:0]         obs_gnt, obs_rvalid;
    logic                 obs_wea;
    logic [AW-1:0]        obs_addra, obs_addrb;
    logic [DW-1:0]        obs_dina;
    logic [N-1:0][DW-1:0] obs_rdata;
    logic [31:0]          obs_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic cycle();
        int a, b, i;
        logic [N-1:0]  eg;
        logic          ewa, ewb;
        logic [AW-1:0] eaa, eab;
        logic [DW-1:0] eda, edb;
        @(posedge clk);
        #1;
        aclr = 1'b0;
        req  = r_req;
        we   = r_we;
        for (int k = 0; k < N; k++) begin
            addr[k]  = r_addr[k];
            wdata[k] = r_wdata[k];
        end
        #3;
        cyc++;
        a = -1;
        b = -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (r_req[i]) begin
                if (a < 0) a = i;
                else if (b < 0 && !(r_addr[i] == r_addr[a] && (r_we[i] || r_we[a]))) b = i;
            end
        end
        eg = '0; ewa = 1'b0; ewb = 1'b0; eaa = '0; eab = '0; eda = '0; edb = '0;
        if (a >= 0) begin
            eg[a] = 1'b1; ewa = r_we[a]; eaa = r_addr[a]; eda = r_wdata[a];
        end
        if (b >= 0) begin
            eg[b] = 1'b1; ewb = r_we[b]; eab = r_addr[b]; edb = r_wdata[b];
        end
        chk("gnt", 32'(gnt), 32'(eg));
        chk("wea", 32'(wea), 32'(ewa));
        chk("addra", 32'(addra), 32'(eaa));
        chk("dina", 32'(dina), 32'(eda));
        chk("web", 32'(web), 32'(ewb));
        chk("addrb", 32'(addrb), 32'(eab));
        chk("dinb", 32'(dinb), 32'(edb));
        chk("ptr", 32'(dut.ptr_reg), 32'(m_ptr));
        chk("rvalid", 32'(rvalid), 32'(p2_v));
        for (int k = 0; k < N; k++)
            chk($sformatf("rdata%0d", k), 32'(rdata[k]), p2_v[k] ? 32'(p2_d[k]) : 32'd0);
        obs_gnt = gnt; obs_rvalid = rvalid; obs_wea = wea; obs_addra = addra;
        obs_addrb = addrb; obs_dina = dina; obs_rdata = rdata; obs_ptr = 32'(dut.ptr_reg);
        if (verbose) begin
            for (int k = 0; k < N; k++)
                if (p2_v[k]) $display("cyc %0d return r%0d data=0x%02h", cyc, k, rdata[k]);
        end
        // Advance the model by one clock.
        for (int k = 0; k < N; k++) p2_d[k] = p1_d[k];
        p2_v = p1_v;
        p1_v = '0;
        for (int k = 0; k < N; k++) begin
            if (eg[k]) begin
                if (verbose)
                    $display("cyc %0d grant r%0d %s addr=0x%02h wdata=0x%02h",
                             cyc, k, r_we[k] ? "wr" : "rd", r_addr[k], r_wdata[k]);
                if (!r_we[k]) begin
                    p1_v[k] = 1'b1;
                    p1_d[k] = refmem[r_addr[k]];
                end
            end
        end
        for (int k = 0; k < N; k++)
            if (eg[k] && r_we[k]) refmem[r_addr[k]] = r_wdata[k];
        if (a >= 0) m_ptr = (((b >= 0) ? b : a) + 1) % N;
        for (int k = 0; k < N; k++) begin
            if (eg[k]) begin
                if (mode == 2) chk("starve", 32'(wait_cnt[k] <= N / 2), 32'd1);
                if (mode == 1) chk("live", 32'(wait_cnt[k] <= 40), 32'd1);
                wait_cnt[k] = 0;
                r_req[k] = 1'b0;
            end else if (r_req[k]) begin
                wait_cnt[k]++;
            end
        end
    endtask

    task automatic reset_cycle();
        @(posedge clk);
        #1;
        aclr = 1'b1;
        req  = r_req;
        #3;
        cyc++;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_web", 32'(web), 32'd0);
        chk("rst_ptr", 32'(dut.ptr_reg), 32'd0);
        if (verbose) $display("cyc %0d reset", cyc);
        m_ptr = 0;
        p1_v  = '0;
        p2_v  = '0;
    endtask

    task automatic gen();
        for (int k = 0; k < N; k++) begin
            if (!r_req[k] && $urandom_range(0, 99) < 60) begin
                r_req[k]   = 1'b1;
                r_we[k]    = ($urandom_range(0, 99) < 30);
                r_addr[k]  = (mode == 1) ? 8'(8'h80 + $urandom_range(0, 7))
                                         : 8'(($urandom_range(0, 63) << 2) | k);
                r_wdata[k] = 8'($urandom);
            end
        end
    endtask

    task automatic clear_reqs();
        r_req = '0;
        r_we  = '0;
        for (int k = 0; k < N; k++) begin
            r_addr[k] = '0; r_wdata[k] = '0; wait_cnt[k] = 0;
        end
    endtask

    initial begin
        logic [DW-1:0] nv;
        aclr = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        m_ptr = 0; p1_v = '0; p2_v = '0; mode = 0; verbose = 1'b1; cyc = 0;
        for (int k = 0; k < N; k++) begin p1_d[k] = '0; p2_d[k] = '0; end
        clear_reqs();
        for (int j = 0; j < 256; j++) refmem[j] = 8'($urandom);
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;

        // Requests present while reset is held must not be granted.
        r_req = '1;
        reset_cycle();
        reset_cycle();
        clear_reqs();

        // Single write right after reset.
        r_req = 4'b0001; r_we = 4'b0001; r_addr[0] = 8'h10; r_wdata[0] = 8'hA5;
        cycle();
        chk("t33_gnt", 32'(obs_gnt), 32'h1);
        chk("t33_wea", 32'(obs_wea), 32'h1);
        chk("t33_addra", 32'(obs_addra), 32'h10);
        chk("t33_dina", 32'(obs_dina), 32'hA5);
        cycle();
        chk("t33_ptr", obs_ptr, 32'd1);

        // Four reads: two per cycle, returns two cycles after each grant.
        reset_cycle();
        r_req = 4'b1111; r_we = '0;
        for (int k = 0; k < N; k++) r_addr[k] = 8'(8'h40 + k);
        cycle();
        chk("t34_gnt0", 32'(obs_gnt), 32'h3);
        cycle();
        chk("t34_gnt1", 32'(obs_gnt), 32'hC);
        cycle();
        chk("t34_rv0", 32'(obs_rvalid), 32'h3);
        chk("t34_rd0", 32'(obs_rdata[0]), 32'(refmem[8'h40]));
        cycle();
        chk("t34_rv1", 32'(obs_rvalid), 32'hC);
        chk("t34_rd3", 32'(obs_rdata[3]), 32'(refmem[8'h43]));

        // Write/read hazard on one address: read waits, then sees new data.
        reset_cycle();
        nv = refmem[8'h20] ^ 8'hFF;
        r_req = 4'b0011; r_we = 4'b0001;
        r_addr[0] = 8'h20; r_wdata[0] = nv; r_addr[1] = 8'h20;
        cycle();
        chk("t35_gnt0", 32'(obs_gnt), 32'h1);
        cycle();
        chk("t35_gnt1", 32'(obs_gnt), 32'h2);
        cycle();
        cycle();
        chk("t35_rv", 32'(obs_rvalid), 32'h2);
        chk("t35_rd1", 32'(obs_rdata[1]), 32'(nv));

        // Two reads of the same address go out together.
        reset_cycle();
        r_req = 4'b1100; r_we = '0; r_addr[2] = 8'h30; r_addr[3] = 8'h30;
        cycle();
        chk("t36_gnt", 32'(obs_gnt), 32'hC);
        chk("t36_addrb", 32'(obs_addrb), 32'h30);
        cycle();
        cycle();
        chk("t36_rv", 32'(obs_rvalid), 32'hC);
        chk("t36_rd2", 32'(obs_rdata[2]), 32'(refmem[8'h30]));
        chk("t36_rd3", 32'(obs_rdata[3]), 32'(refmem[8'h30]));

        // Reset pulse one cycle after a read grant kills the return.
        reset_cycle();
        r_req = 4'b0001; r_we = '0; r_addr[0] = 8'h50;
        cycle();
        chk("t37_gnt", 32'(obs_gnt), 32'h1);
        reset_cycle();
        cycle();
        chk("t37_rv", 32'(obs_rvalid), 32'h0);
        chk("t37_ptr", obs_ptr, 32'd0);

        // Random traffic on a small shared address pool (hazards likely).
        verbose = 1'b0;
        reset_cycle();
        clear_reqs();
        mode = 1;
        for (int c = 0; c < 6000; c++) begin
            gen();
            if (c % 1500 == 777) reset_cycle();
            cycle();
            if (c % 1000 == 999) $display("random pool phase: %0d cycles, %0d vectors", c + 1, n_vec);
        end

        // Random traffic with per-requester address sets (no hazards): fairness.
        reset_cycle();
        clear_reqs();
        mode = 2;
        for (int c = 0; c < 4000; c++) begin
            gen();
            cycle();
            if (c % 1000 == 999) $display("random fair phase: %0d cycles, %0d vectors", c + 1, n_vec);
        end
        r_req = '0;
        cycle();
        cycle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bram_arb.md
BRAM_ARB -- requirements
Module: bram_arb

Interface
REQ-001 SHALL have parameter ADDR_, default 8, BRAM address width.
REQ-002 SHALL have parameter DATA_, default 8, BRAM data width.
REQ-003 SHALL have parameter N_, default 4, number of requesters (2..8).
REQ-004 SHALL have port clk  in  1  single clock; all state rising-edge.
REQ-005 SHALL have port aclr  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req, we  in  N_  per-requester access request and write flag.
REQ-007 SHALL have ports addr  in  N_ x ADDR_, and wdata  in  N_ x DATA_, per-requester address and write data.
REQ-008 SHALL have port gnt  out  N_  per-requester grant; transfer occurs when req & gnt.
REQ-009 SHALL have ports rvalid  out  N_, and rdata  out  N_ x DATA_, read return per requester.
REQ-010 SHALL have ports wea, web  out  1, addra, addrb  out  ADDR_, dina, dinb  out  DATA_; these drive the dual-port BRAM.
REQ-011 SHALL have ports douta, doutb  in  DATA_  BRAM read data.

Function
REQ-012 SHALL grant at most two requesters per cycle: first candidate to port A, second to port B.
REQ-013 SHALL scan candidates round-robin, starting at pointer ptr, in ascending index order modulo N_.
REQ-014 SHALL drive gnt, wea/web, addra/addrb and dina/dinb combinationally in the grant cycle.
REQ-015 SHALL hold an unused port at we=0, with addr and din equal to 0.
REQ-016 SHALL skip a port-B candidate with the same address as the port-A grant if either access writes, and SHALL continue the scan to the next candidate.
REQ-017 SHALL grant two reads to the same address on both ports.
REQ-018 SHALL update ptr to (last granted index + 1) mod N_ on any grant, and SHALL hold ptr when nothing is granted.
REQ-019 SHALL carry a 2-stage registered pipeline per port: valid bit plus requester id; writes enter with valid=0.
REQ-020 SHALL assert rvalid[id] exactly 2 cycles after the grant cycle of a read, for one cycle.
REQ-021 SHALL drive rdata[id] in that cycle from douta or doutb, according to the originating port.
REQ-022 SHALL drive rdata of non-valid requesters to 0.
REQ-023 SHALL return read-during-write on the same port as new data, consistent with the BRAM configuration.
REQ-024 SHALL accept requester behaviour where req is held with stable we/addr/wdata until granted; gnt never depends on past gnt.
REQ-025 SHALL sustain full throughput: 2 accesses per cycle with no bubble between back-to-back grants.
REQ-026 SHALL assert rvalid to two different requesters in the same cycle when both ports return.

Reset
REQ-027 SHALL, while aclr=1: ptr=0, all pipeline valids=0, gnt=0, rvalid=0, rdata=0, wea=web=0.
REQ-028 SHALL drop in-flight reads on aclr mid-operation; no rvalid is produced for them after release.
REQ-029 SHALL allow grants in the first clock cycle after aclr deasserts.

Structure
REQ-030 SHALL place the read latency constant (2) and the pipeline-entry struct (valid, id of width $clog2(N_)) in the shared utils ram package.
REQ-031 SHALL implement the round-robin search as one sub-module, rr_pick (mask in, start index in, first index and found flag out), instantiated twice.
REQ-032 SHALL NOT instantiate the BRAM; the parent connects it to bramd.

Verification (N_=4, ADDR_=8, DATA_=8, BRAM model with 2-cycle read)
REQ-033 SHALL cover: after reset, req=0001 we=1 addr0=0x10 wdata0=0xA5 -> gnt=0001, wea=1, addra=0x10, dina=0xA5, ptr=1.
REQ-034 SHALL cover: req=1111 all reads, held 2 cycles -> gnt 0011 then 1100; rvalid 0011 at T+2, 1100 at T+3, with correct data.
REQ-035 SHALL cover: req=0011, r0 write 0x20, r1 read 0x20 -> gnt=0001 only; r1 granted next cycle; rvalid1 returns new data.
REQ-036 SHALL cover: r2 and r3 read 0x30 simultaneously -> gnt=1100, both rvalid at T+2 with the same data.
REQ-037 SHALL cover: read granted at T, aclr pulsed at T+1 -> no rvalid at T+2; ptr=0 after release.
REQ-038 SHALL cover: random 10k cycles against a scoreboard -> no requester starves longer than N_/2 cycles; all reads match the memory model.
